// File: rtl/strip_ila_pkg.sv
// Shared definitions for the strip-data frame checker logic analyzer.
// Holds the capture FSM state codes, trigger mode encodings, the probe widths
// and the bit positions of the probe fields inside one captured sample.
package strip_ila_pkg;

    // Probe widths, probe0 first.
    localparam int P0_W = 30;
    localparam int P1_W = 19;
    localparam int P2_W = 104;
    localparam int P3_W = 4;
    localparam int P4_W = 2;
    localparam int P5_W = 2;
    localparam int P6_W = 1;
    localparam int P7_W = 104;

    // Sample = {probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0}.
    localparam int SW = P0_W + P1_W + P2_W + P3_W + P4_W + P5_W + P6_W + P7_W;

    // Field positions used by the trigger logic.
    localparam int HDR_LSB = 26;                          // probe0[29:26]
    localparam int P3_LSB  = P0_W + P1_W + P2_W;          // probe3 in sample
    localparam int P6_BIT  = P3_LSB + P3_W + P4_W + P5_W; // probe6 in sample

    // Capture FSM states.
    typedef logic [2:0] ila_state_t;
    localparam ila_state_t S_IDLE = 3'd0;
    localparam ila_state_t S_PRE  = 3'd1;
    localparam ila_state_t S_WAIT = 3'd2;
    localparam ila_state_t S_POST = 3'd3;
    localparam ila_state_t S_DONE = 3'd4;

    // Trigger mode encodings.
    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_VALID     = 2'd1;
    localparam logic [1:0] TRIG_HEADER    = 2'd2;
    localparam logic [1:0] TRIG_HDR_EDGE  = 2'd3;

endpackage

// File: rtl/strip_ila_ram.sv
// Capture memory: W-wide, DEPTH-deep simple dual-port RAM.
// Ports: clk; reset (clears only the read register); we/wr_addr/wr_data
// write port; rd_addr/rd_data read port with one cycle of latency.
module strip_ila_ram
    import strip_ila_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = SW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Array contents are never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/strip_data_check_ila.sv
// On-chip logic analyzer for the strip-data frame checker.
// Every clock the eight probe buses form one SW-bit sample that is written to
// a circular capture RAM while a capture is running. A programmable trigger
// ends the capture DEPTH samples after the window start, with the trigger
// sample at window index trig_pos.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   probe0..probe7          sampled buses (probe0[29:26] is the header)
//   arm                     one-cycle pulse, (re)starts a capture
//   trig_mode, trig_header  trigger select and header compare value (live)
//   trig_pos                pretrigger sample count (sampled at arm)
//   rd_addr, rd_data        random-access readout, 1-cycle latency
//   armed, triggered, done  capture status
//   start_addr              RAM address of window sample 0 (valid when done)
//   dbg_state               capture FSM state
//
// Build option: define ILA_INPUT_PIPE_EN to register all probes once before
// the trigger compare and RAM write (capture shifts one cycle later).
module strip_data_check_ila
    import strip_ila_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [P0_W-1:0]   probe0,
    input  logic [P1_W-1:0]   probe1,
    input  logic [P2_W-1:0]   probe2,
    input  logic [P3_W-1:0]   probe3,
    input  logic [P4_W-1:0]   probe4,
    input  logic [P5_W-1:0]   probe5,
    input  logic [P6_W-1:0]   probe6,
    input  logic [P7_W-1:0]   probe7,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [3:0]        trig_header,
    input  logic [AW-1:0]     trig_pos,
    input  logic [AW-1:0]     rd_addr,
    output logic [SW-1:0]     rd_data,
    output logic              armed,
    output logic              triggered,
    output logic              done,
    output logic [AW-1:0]     start_addr,
    output ila_state_t        dbg_state
);

    logic [SW-1:0] sample_raw;
    logic [SW-1:0] sample;

    assign sample_raw = {probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};

`ifdef ILA_INPUT_PIPE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sample <= '0;
        end else begin
            sample <= sample_raw;
        end
    end
`else
    assign sample = sample_raw;
`endif

    // Trigger condition on the sample being written this cycle.
    logic [3:0] cur_hdr;
    logic [3:0] prev_hdr;
    logic       trig_hit;

    assign cur_hdr  = sample[HDR_LSB +: 4];
    assign prev_hdr = sample[P3_LSB +: P3_W];

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            TRIG_IMMEDIATE: trig_hit = 1'b1;
            TRIG_VALID:     trig_hit = sample[P6_BIT];
            TRIG_HEADER:    trig_hit = (cur_hdr == trig_header);
            default:        trig_hit = (cur_hdr == trig_header) && (prev_hdr != trig_header);
        endcase
    end

    ila_state_t    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] trig_pos_q;
    logic [AW-1:0] post_left;
    logic [AW-1:0] post_init;
    logic          we;

    // Samples still to be written after the trigger sample.
    assign post_init = AW'(DEPTH - 1) - trig_pos_q;

    // The arm cycle itself never writes; the first window sample is the one
    // presented on the cycle after arm.
    assign we = !arm && ((state == S_PRE) || (state == S_WAIT) || (state == S_POST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            trig_pos_q <= '0;
            post_left  <= '0;
            start_addr <= '0;
        end else if (arm) begin
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            trig_pos_q <= trig_pos;
            state      <= (trig_pos != '0) ? S_PRE : S_WAIT;
        end else begin
            case (state)
                S_PRE: begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    pre_cnt <= pre_cnt + AW'(1);
                    if (pre_cnt + AW'(1) == trig_pos_q) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (trig_hit) begin
                        // wr_ptr is the trigger sample's address here.
                        start_addr <= wr_ptr - trig_pos_q;
                        post_left  <= post_init;
                        state      <= (post_init == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_ptr    <= wr_ptr + AW'(1);
                    post_left <= post_left - AW'(1);
                    if (post_left == AW'(1)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign armed     = (state == S_PRE) || (state == S_WAIT);
    assign triggered = (state == S_POST);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    strip_ila_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (SW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (sample),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_strip_data_check_ila.sv
// Bench for strip_data_check_ila. Each capture is driven from a prepared
// sample stream; a reference model finds the trigger in that stream from the
// trigger rules, derives the window and start address, and the whole RAM is
// read back and compared.
module tb_strip_data_check_ila;
  import strip_ila_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW = 6;
`ifdef ILA_INPUT_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [P0_W-1:0] probe0;
  logic [P1_W-1:0] probe1;
  logic [P2_W-1:0] probe2;
  logic [P3_W-1:0] probe3;
  logic [P4_W-1:0] probe4;
  logic [P5_W-1:0] probe5;
  logic [P6_W-1:0] probe6;
  logic [P7_W-1:0] probe7;
  logic arm;
  logic [1:0] trig_mode;
  logic [3:0] trig_header;
  logic [AW-1:0] trig_pos;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_data;
  logic armed, triggered, done;
  logic [AW-1:0] start_addr;
  ila_state_t dbg_state;

  always #5 clk = ~clk;

  strip_data_check_ila #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
    .probe4(probe4), .probe5(probe5), .probe6(probe6), .probe7(probe7),
    .arm(arm), .trig_mode(trig_mode), .trig_header(trig_header),
    .trig_pos(trig_pos), .rd_addr(rd_addr), .rd_data(rd_data),
    .armed(armed), .triggered(triggered), .done(done),
    .start_addr(start_addr), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [SW-1:0] stim_q[$];  // stim_q[0] is presented during the arm cycle
  logic [SW-1:0] exp_q[$];   // expected RAM contents in address order

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [SW-1:0] filler(input logic [3:0] hdr);
    logic [287:0] wide;
    logic [SW-1:0] s;
    logic [3:0] h;
    for (int k = 0; k < 9; k++) wide[k*32 +: 32] = $urandom();
    s = wide[SW-1:0];
    h = 4'($urandom_range(0, 15));
    if (h == hdr) h = h + 4'd1;
    s[29:26] = h;
    s[161] = 1'b0;
    return s;
  endfunction

  task automatic new_stream(input logic [3:0] hdr, input int len);
    stim_q.delete();
    for (int i = 0; i < len + 1; i++) stim_q.push_back(filler(hdr));
  endtask

  // Puts a trigger event (header match and valid pulse) at drive index d.
  task automatic inject(input int d, input logic [3:0] hdr);
    logic [SW-1:0] s;
    s = stim_q[d + 1];
    s[29:26] = hdr;
    s[161] = 1'b1;
    stim_q[d + 1] = s;
  endtask

  // probe3 carries the previous sample's header, as in the real checker.
  task automatic fix_prev();
    logic [SW-1:0] s;
    for (int i = 1; i < stim_q.size(); i++) begin
      s = stim_q[i];
      s[156:153] = stim_q[i-1][29:26];
      stim_q[i] = s;
    end
  endtask

  task automatic drive(input logic [SW-1:0] s);
    probe0 = s[29:0];
    probe1 = s[48:30];
    probe2 = s[152:49];
    probe3 = s[156:153];
    probe4 = s[158:157];
    probe5 = s[160:159];
    probe6 = s[161];
    probe7 = s[265:162];
  endtask

  // ---------------- reference model ----------------
  function automatic bit hit(input logic [SW-1:0] s, input logic [1:0] mode, input logic [3:0] hdr);
    case (mode)
      2'd0: return 1'b1;
      2'd1: return s[161];
      2'd2: return s[29:26] == hdr;
      default: return (s[29:26] == hdr) && (s[156:153] != hdr);
    endcase
  endfunction

  // Samples land in RAM in stream order starting at address 0; the trigger is
  // the first hit at or after stream index p; the window is the DEPTH samples
  // starting p before it.
  task automatic model(input logic [1:0] mode, input logic [3:0] hdr, input int p,
                       output int t, output int start);
    logic [SW-1:0] m[$];
    m = stim_q;
    if (PIPE == 0) void'(m.pop_front());
    t = -1;
    for (int i = p; i < m.size(); i++) begin
      if (hit(m[i], mode, hdr)) begin
        t = i;
        break;
      end
    end
    if (t < 0) t = p;
    start = (t - p) % DEPTH;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(m[t - p + ((a - start + DEPTH) % DEPTH)]);
  endtask

  task automatic arm_start(input logic [1:0] mode, input logic [3:0] hdr, input int p);
    @(negedge clk);
    arm = 1'b1;
    trig_mode = mode;
    trig_header = hdr;
    trig_pos = AW'(p);
    drive(stim_q[0]);
  endtask

  // Runs one capture from the prepared stream and checks status, timing,
  // start address and every RAM word.
  task automatic run_capture(input logic [1:0] mode, input logic [3:0] hdr, input int p,
                             input string name, output int start_seen);
    int t, start, cyc, n_arm, n_trig;
    model(mode, hdr, p, t, start);
    arm_start(mode, hdr, p);
    @(posedge clk); #1;
    check({name, "_armed_after_arm"}, armed, 1'b1);
    check({name, "_done_cleared"}, done, 1'b0);
    cyc = 0; n_arm = 0; n_trig = 0;
    for (int j = 0; j < 600 && !done; j++) begin
      @(negedge clk);
      arm = 1'b0;
      trig_pos = AW'($urandom());  // must be ignored until the next arm
      drive((j + 1 < stim_q.size()) ? stim_q[j + 1] : filler(hdr));
      @(posedge clk); #1;
      cyc++;
      if (armed) n_arm++;
      if (triggered) n_trig++;
    end
    check({name, "_done"}, done, 1'b1);
    check({name, "_cycles_to_done"}, cyc, t - p + DEPTH);
    check({name, "_armed_cycles"}, n_arm, t);
    check({name, "_triggered_cycles"}, n_trig, DEPTH - p - 1);
    check({name, "_start_addr"}, start_addr, start);
    start_seen = int'(start_addr);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      @(posedge clk); #1;
      check($sformatf("%s_rd%0d", name, a), rd_data, exp_q.pop_front());
    end
    check({name, "_done_held"}, done, 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0] mode;
    logic [3:0] hdr;
    int pos;
    int inj;        // drive index of the trigger event, -1 for none
    int decoy;      // drive index of an event inside PRE, -1 for none
    int burst;      // number of consecutive trigger events
    int exp_start;  // start_addr without the input pipe
  } vec_t;

  vec_t tab[8];

  initial begin
    int s_seen, exp_s;
    tab[0] = '{2'd0, 4'h0, 0, -1, -1, 1, 0};
    tab[1] = '{2'd2, 4'hA, 8, 20, -1, 1, 12};
    tab[2] = '{2'd2, 4'h3, 0, 5, -1, 1, 5};
    tab[3] = '{2'd1, 4'h0, 63, 70, -1, 1, 7};
    tab[4] = '{2'd2, 4'hC, 1, 100, -1, 1, 35};
    tab[5] = '{2'd3, 4'h5, 4, 10, -1, 1, 6};
    tab[6] = '{2'd1, 4'h0, 16, 40, 5, 1, 24};
    tab[7] = '{2'd3, 4'hA, 4, 10, -1, 3, 6};

    reset = 1'b1; arm = 1'b0; trig_mode = 2'd0; trig_header = 4'd0;
    trig_pos = '0; rd_addr = '0;
    drive('0);
    repeat (3) @(negedge clk);
    check("reset_armed", armed, 1'b0);
    check("reset_triggered", triggered, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_start_addr", start_addr, '0);
    check("reset_rd_data", rd_data, '0);
    check("reset_state", dbg_state, S_IDLE);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      new_stream(tab[v].hdr, 320);
      if (tab[v].decoy >= 0) inject(tab[v].decoy, tab[v].hdr);
      if (tab[v].inj >= 0)
        for (int b = 0; b < tab[v].burst; b++) inject(tab[v].inj + b, tab[v].hdr);
      fix_prev();
      run_capture(tab[v].mode, tab[v].hdr, tab[v].pos, $sformatf("tab%0d", v), s_seen);
      exp_s = (tab[v].mode == 2'd0) ? tab[v].exp_start : (tab[v].exp_start + PIPE) % DEPTH;
      check($sformatf("tab%0d_start_table", v), s_seen, exp_s);
    end

    // Arm while a capture is in POST: the new capture takes over.
    new_stream(4'h0, 320);
    fix_prev();
    arm_start(2'd0, 4'h0, 0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      arm = 1'b0;
      drive(stim_q[j + 1]);
    end
    check("post_triggered", triggered, 1'b1);
    check("post_done", done, 1'b0);
    new_stream(4'hA, 320);
    inject(30, 4'hA);
    fix_prev();
    run_capture(2'd2, 4'hA, 8, "rearm", s_seen);

    // Reset in WAIT, together with an arm that must lose.
    new_stream(4'h9, 320);
    fix_prev();
    arm_start(2'd2, 4'h9, 2);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      arm = 1'b0;
      drive(stim_q[j + 1]);
    end
    check("wait_armed", armed, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    arm = 1'b1;
    @(posedge clk); #1;
    check("rst_armed", armed, 1'b0);
    check("rst_triggered", triggered, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_start_addr", start_addr, '0);
    check("rst_rd_data", rd_data, '0);
    @(negedge clk);
    reset = 1'b0;
    arm = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stays_idle", dbg_state, S_IDLE);

    // Randomized captures against the model.
    for (int r = 0; r < 6; r++) begin
      logic [1:0] mode;
      logic [3:0] hdr;
      int p;
      mode = 2'($urandom_range(0, 3));
      hdr = 4'($urandom_range(0, 15));
      p = $urandom_range(0, DEPTH - 1);
      new_stream(hdr, 320);
      if (p > 0 && $urandom_range(0, 1) == 1) inject($urandom_range(0, p - 1), hdr);
      inject(p + $urandom_range(0, 120), hdr);
      fix_prev();
      run_capture(mode, hdr, p, $sformatf("rnd%0d", r), s_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
